// File: rtl/p_wff_pkg.sv
// Shared constants, helper function and scan-FSM state type for the p_wff core
// and its downstream consumers.
package p_wff_pkg;

  localparam int EX_WIDTH = 14;
  localparam int MF_WIDTH = 22;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } flow_state_e;

  // Ceiling log2, never below 1 so a one-entry array still gets an address bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/flow_acc_add.sv
// Combinational accumulate step: adds a sign-extended excess word to the
// accumulator only when it is negative. Clamping is compiled in with SINK_FLOW_SAT_EN.
module flow_acc_add #(
  parameter int EX_WIDTH = p_wff_pkg::EX_WIDTH,
  parameter int MF_WIDTH = p_wff_pkg::MF_WIDTH
) (
  input  logic [MF_WIDTH-1:0] acc,
  input  logic [EX_WIDTH-1:0] data,
  output logic [MF_WIDTH-1:0] sum,
  output logic                sat_hit
);

  logic                neg;
  logic [MF_WIDTH-1:0] data_sext;

  assign neg       = data[EX_WIDTH-1];
  assign data_sext = MF_WIDTH'($signed(data));

`ifdef SINK_FLOW_SAT_EN
  // Two guard bits: bit MF_WIDTH+1 flags a negative result, bit MF_WIDTH an overflow.
  logic [MF_WIDTH+1:0] wide;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sum     = acc;
    sat_hit = 1'b0;
    wide    = {2'b00, acc} + {{2{data_sext[MF_WIDTH-1]}}, data_sext};
    if (neg) begin
      if (wide[MF_WIDTH+1]) begin
        sum     = '0;
        sat_hit = 1'b1;
      end else if (wide[MF_WIDTH]) begin
        sum     = '1;
        sat_hit = 1'b1;
      end else begin
        sum = wide[MF_WIDTH-1:0];
      end
    end
  end
`else
  assign sum     = neg ? (acc + data_sext) : acc;
  assign sat_hit = 1'b0;
`endif

endmodule

// File: rtl/sink_flow_accum.sv
// Scans the sink-excess array after the core finishes and accumulates negative
// entries onto INIT_FLOW. Optional clamping: define SINK_FLOW_SAT_EN.
module sink_flow_accum
  import p_wff_pkg::*;
#(
  parameter int X          = 129,
  parameter int Y          = 129,
  parameter int EX_WIDTH   = p_wff_pkg::EX_WIDTH,
  parameter int MF_WIDTH   = p_wff_pkg::MF_WIDTH,
  parameter int INIT_FLOW  = 1971855,
  parameter int ADDR_WIDTH = p_wff_pkg::clog2(X * Y)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  finish,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [EX_WIDTH-1:0]   rd_data,
  output logic [MF_WIDTH-1:0]   max_flow,
  output logic                  busy,
  output logic                  done,
  output logic                  sat
);

  localparam int                    XY        = X * Y;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(XY - 1);
  localparam logic [MF_WIDTH-1:0]   INIT_VAL  = MF_WIDTH'(INIT_FLOW);

  flow_state_e         state;
  logic                rd_pending;
  logic [MF_WIDTH-1:0] acc;
  logic [MF_WIDTH-1:0] acc_next;
  logic                sat_hit;
  logic                sat_q;

  flow_acc_add #(
    .EX_WIDTH(EX_WIDTH),
    .MF_WIDTH(MF_WIDTH)
  ) u_add (
    .acc    (acc),
    .data   (rd_data),
    .sum    (acc_next),
    .sat_hit(sat_hit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_pending <= 1'b0;
      acc        <= INIT_VAL;
      sat_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Data for a strobe arrives one cycle later; rd_pending marks that cycle.
      rd_pending <= rd_en;
      if (rd_pending) begin
        acc   <= acc_next;
        sat_q <= sat_q | sat_hit;
      end

      case (state)
        IDLE: begin
          if (finish) begin
            state   <= SCAN;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            acc     <= INIT_VAL;
            sat_q   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (rd_addr == LAST_ADDR) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Leave only once the final in-flight read has been absorbed.
          if (!rd_pending) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!finish) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign max_flow = acc;
  assign sat      = sat_q;

endmodule

// File: doc/sink_flow_accum.md
# sink_flow_accum

Downstream consumer of the pipelined wave-front-flow core (`p_wff`). Once the core raises `finish`, this block scans the sink-excess array (`e_r_sink`, X*Y entries, one per column) through a synchronous read port. It accumulates every negative entry onto an initial flow value and presents the resulting max-flow with a `done` flag. It is the hardware replacement for the software summation loop in the simulation bench.

## Interface
Parameters:
- `X`, default 129: grid width.
- `Y`, default 129: grid height. XY = X*Y entries are scanned.
- `EX_WIDTH`, default 14: excess word width, two's complement.
- `MF_WIDTH`, default 22: accumulator and result width.
- `INIT_FLOW`, default 1971855: accumulator start value; must fit in MF_WIDTH bits, unsigned.
- `ADDR_WIDTH`, default clog2(X*Y): read-address width. Derived; do not override.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `finish`, in, 1: core-finished level from `p_wff`.
- `rd_en`, out, 1: read strobe to the sink-excess storage.
- `rd_addr`, out, ADDR_WIDTH: entry index, 0..XY-1.
- `rd_data`, in, EX_WIDTH: excess for the address presented on the previous cycle.
- `max_flow`, out, MF_WIDTH: accumulated result. Held while `done`.
- `busy`, out, 1: high in SCAN and DRAIN.
- `done`, out, 1: result valid.
- `sat`, out, 1: sticky underflow/overflow indicator. See Configuration.

## Operation
- The FSM has four states:
  - IDLE: `finish`=1 → SCAN. Accumulator loads INIT_FLOW, `sat` clears, `rd_addr`=0.
  - SCAN: `rd_en`=1 and `rd_addr` increments each cycle. After issuing address XY-1 → DRAIN.
  - DRAIN: one cycle that absorbs the final read, then → DONE.
  - DONE: `done`=1. `finish`=0 → IDLE. A new run requires `finish` to drop and rise again.
- Accumulate rule:
  - The cycle after each `rd_en`, if `rd_data[EX_WIDTH-1]`=1, the accumulator takes acc + sext(`rd_data`).
  - Otherwise the accumulator is unchanged. Zero and positive entries contribute nothing.
- Arithmetic: `rd_data` is sign-extended to MF_WIDTH. The sum wraps modulo 2^MF_WIDTH unless saturation is compiled in.
- `finish` falling during SCAN or DRAIN is ignored; the scan always runs to completion.
- `max_flow` reflects the live accumulator in SCAN and DRAIN. Consumers must qualify it with `done`.
- `rd_addr` never exceeds XY-1. Out-of-range addresses are never issued. The address counter does not wrap.

## Timing
- Reset values: state IDLE, `rd_en`=0, `rd_addr`=0, `max_flow`=INIT_FLOW, `busy`=0, `done`=0, `sat`=0.
- Reset asserted mid-scan aborts immediately to these values. Reads still in flight are discarded.
- Read latency: `rd_data` is sampled exactly one cycle after the corresponding `rd_en`. This matches the BRAM/register-array read of the core.
- Scan schedule (edge E0 is the one where `finish`=1 is sampled in IDLE):
  - `rd_en` is high for cycles 1..XY.
  - The last datum is accumulated at edge XY+1.
  - `done` rises at edge XY+2, with `busy` low in the same cycle.
  - Total latency is XY+2 cycles.
- Throughput: one entry per cycle, with no bubbles.
- `rd_en` and `rd_addr` are registered outputs.

## Configuration
- `SINK_FLOW_SAT_EN` defined:
  - The accumulator saturates at 0 on underflow and at 2^MF_WIDTH-1 on overflow.
  - `sat` sets on the first clamp and stays set until the next IDLE→SCAN transition or reset.
- `SINK_FLOW_SAT_EN` undefined:
  - The accumulator wraps modulo 2^MF_WIDTH.
  - `sat` is tied to 0. The port still exists, so the interface is identical in both builds.

## Structure
- Shared package `p_wff_pkg`, containing:
  - the EX_WIDTH and MF_WIDTH constants shared with `p_wff`;
  - the `clog2` function;
  - the FSM state enum (IDLE/SCAN/DRAIN/DONE).
- One sub-module, `flow_acc_add`, which is combinational: sign-extend, negative-gate, add, and optional clamp (`sat_hit` output). The top level holds the FSM, address counter and accumulator register.

## Test plan
All scenarios use X=Y=2 (XY=4) and INIT_FLOW=100 unless noted.
- Mixed entries: data [-5, 3, -10, 0] → `max_flow`=85. `done` rises exactly 6 cycles after `finish` is sampled. `rd_addr` sequence is 0,1,2,3.
- Non-negative entries: data [0, 7, 1, 8191] → `max_flow`=100, `sat`=0.
- Underflow: data [-8192, -8192, -8192, -8192].
  - With SINK_FLOW_SAT_EN: `max_flow`=0, `sat`=1.
  - Without: `max_flow`=4161636 (100-32768 mod 2^22), `sat`=0.
- Reset mid-scan: assert `rst` during the 2nd read → all outputs return to reset values. Re-raising `finish` yields the correct result from scratch.
- Re-arm: hold `finish` high after `done` → no second scan. Drop `finish`, then raise it with new data [-1, -1, -1, -1] → `max_flow`=96.
- Full size: X=Y=129, INIT_FLOW=1971855, with the `e_r_sink` image loaded from the core's 129x129x16_0 run → `max_flow`=545133. `done` rises 16643 cycles after `finish`.
